// File: rtl/rx_deframer_pkg.sv
// Shared HDLC/Econet definitions for the receive deframer and transmit framer:
// line constants, CRC-16/X.25 parameters, receive state encoding.
package econet_hdlc_pkg;

    localparam logic [7:0]  FLAG          = 8'h7E;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL = 16'h8408;
    localparam logic [15:0] CRC_GOOD      = 16'hF0B8;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SYNC,
        ST_DATA,
        ST_ABORT
    } rx_state_t;

    // One reflected CRC step; the register shifts toward bit 0 as bits arrive LSB-first.
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return fb ? ((crc >> 1) ^ CRC_POLY_REFL) : (crc >> 1);
    endfunction

endpackage

// File: rtl/rx_deframer_if.sv
// Byte-side outputs of the receive deframer: payload strobe plus frame status levels.
interface rx_deframer_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_crc_ok;
    logic       rx_error;
    logic       abort;
    logic       idle;

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_error, abort, idle
    );

    modport slave (
        input rx_data, rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_error, abort, idle
    );

endinterface

// File: rtl/rx_deframer_crc16.sv
// Bit-serial CRC-16/X.25 register with clear and good-residual compare.
module hdlc_crc16
    import econet_hdlc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic din,
    output logic good
);

    logic [15:0] crc;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_bit(crc, din);
        end
    end

    assign good = (crc == CRC_GOOD);

endmodule

// File: rtl/rx_deframer.sv
// HDLC/Econet receive deframer: flag/abort/idle detection, zero removal, LSB-first
// byte assembly, CRC-16/X.25 check and FCS stripping, one line bit per clk.
module rx_deframer
    import econet_hdlc_pkg::*;
#(
    parameter int IDLE_ONES = 15,
    parameter int MIN_BYTES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxdata,
    rx_deframer_if.master rx
);

    localparam int             BCW    = $clog2(MIN_BYTES + 1);
    localparam logic [BCW-1:0] MIN_B  = BCW'(MIN_BYTES);
    localparam logic [3:0]     IDLE_N = 4'(IDLE_ONES);

    rx_state_t state, state_nxt;

    logic [3:0]       ones_cnt, ones_nxt;
    logic             ev_stuff, ev_flag, ev_abort;
    logic             data_bit, commit, byte_done, eof_evt, frame_err;
    logic [6:0]       la;
    logic [2:0]       la_cnt;
    logic [7:0]       byte_sr, new_byte;
    logic [2:0]       bit_cnt;
    logic [BCW-1:0]   byte_cnt;
    logic [1:0][7:0]  hold;
    logic [1:0]       vld_pipe;
    logic             sof_pend;
    logic             crc_good;

    // Line-level events, all decoded from the ones run length before this bit.
    assign ev_stuff = !rxdata && (ones_cnt == 4'd5);
    assign ev_flag  = !rxdata && (ones_cnt == 4'd6);
    assign ev_abort =  rxdata && (ones_cnt == 4'd6);
    assign ones_nxt = !rxdata ? 4'd0 : (ones_cnt == 4'd15) ? 4'd15 : ones_cnt + 4'd1;

    // A bit leaves the 7-deep lookahead only once it cannot be part of a flag.
    assign data_bit  = (state == ST_SYNC || state == ST_DATA) && !ev_stuff && !ev_flag && !ev_abort;
    assign commit    = data_bit && (la_cnt == 3'd7);
    assign new_byte  = {la[0], byte_sr[7:1]};
    assign byte_done = commit && (bit_cnt == 3'd7);
    assign frame_err = (bit_cnt != 3'd0) || (byte_cnt < MIN_B);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        eof_evt   = 1'b0;
        if (ev_flag) begin
            state_nxt = ST_SYNC;
            eof_evt   = (state == ST_DATA);
        end else if (ev_abort) begin
            state_nxt = ST_ABORT;
        end else if (commit && state == ST_SYNC) begin
            state_nxt = ST_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ones_cnt     <= 4'd0;
            la           <= 7'd0;
            la_cnt       <= 3'd0;
            byte_sr      <= 8'h00;
            bit_cnt      <= 3'd0;
            byte_cnt     <= '0;
            hold         <= '0;
            vld_pipe     <= 2'b00;
            sof_pend     <= 1'b0;
            rx.rx_data   <= 8'h00;
            rx.rx_valid  <= 1'b0;
            rx.rx_sof    <= 1'b0;
            rx.rx_eof    <= 1'b0;
            rx.rx_crc_ok <= 1'b0;
            rx.rx_error  <= 1'b0;
            rx.abort     <= 1'b0;
            rx.idle      <= 1'b0;
        end else begin
            ones_cnt     <= ones_nxt;
            rx.rx_valid  <= 1'b0;
            rx.rx_sof    <= 1'b0;
            rx.rx_eof    <= 1'b0;
            rx.rx_crc_ok <= 1'b0;
            rx.rx_error  <= 1'b0;

            if (!rxdata) begin
                rx.idle <= 1'b0;
            end else if (ones_nxt == IDLE_N) begin
                rx.idle <= 1'b1;
            end

            if (ev_abort) begin
                rx.abort <= 1'b1;
            end else if (ev_flag) begin
                rx.abort <= 1'b0;
            end

            // Flag or abort drops the lookahead and the two held bytes (FCS on a flag).
            if (ev_flag || ev_abort) begin
                la_cnt   <= 3'd0;
                bit_cnt  <= 3'd0;
                byte_cnt <= '0;
                vld_pipe <= 2'b00;
                sof_pend <= 1'b1;
            end else if (data_bit) begin
                la <= {rxdata, la[6:1]};
                if (la_cnt != 3'd7) begin
                    la_cnt <= la_cnt + 3'd1;
                end
                if (commit) begin
                    byte_sr <= new_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    hold     <= {hold[0], new_byte};
                    vld_pipe <= {vld_pipe[0], 1'b1};
                    if (byte_cnt != MIN_B) begin
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                    if (vld_pipe[1]) begin
                        rx.rx_valid <= 1'b1;
                        rx.rx_data  <= hold[1];
                        rx.rx_sof   <= sof_pend;
                        sof_pend    <= 1'b0;
                    end
                end
            end

            if (eof_evt) begin
                rx.rx_eof    <= 1'b1;
                rx.rx_error  <= frame_err;
                rx.rx_crc_ok <= !frame_err && crc_good;
            end
        end
    end

    hdlc_crc16 u_crc (
        .clk   (clk),
        .reset (reset),
        .clear (ev_flag || ev_abort),
        .en    (commit),
        .din   (la[0]),
        .good  (crc_good)
    );

endmodule

// File: tb/tb_rx_deframer.sv
// Directed and randomized frames for rx_deframer, checked against a frame-level
// model built from the payload bits (byte delay, length rules, FCS match).
module tb_rx_deframer;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic rxdata = 1'b1;

    rx_deframer_if rif();

    rx_deframer #(.IDLE_ONES(15), .MIN_BYTES(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .rxdata (rxdata),
        .rx     (rif)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nerr = 0;
    logic       frm[$];
    logic [8:0] exp_b[$], got_b[$];
    logic [1:0] exp_e[$], got_e[$];
    logic       abort_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one line bit, let the DUT sample it, then record any output event.
    task automatic send_bit(input logic b);
        rxdata = b;
        @(posedge clk);
        #1;
        if (rif.rx_valid) got_b.push_back({rif.rx_sof, rif.rx_data});
        if (rif.rx_eof)   got_e.push_back({rif.rx_crc_ok, rif.rx_error});
        if (rif.abort)    abort_seen = 1'b1;
    endtask

    task automatic send_raw8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_flag();
        send_raw8(8'h7E);
    endtask

    task automatic add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) frm.push_back(v[i]);
    endtask

    function automatic logic [15:0] crc_over(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[0] ^ frm[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    task automatic add_fcs();
        logic [15:0] f;
        f = ~crc_over(frm.size());
        for (int i = 0; i < 16; i++) frm.push_back(f[i]);
    endtask

    // Expected outputs: every octet except the last two, then a status that
    // depends on octet alignment, octet count and whether the tail is ~CRC(body).
    task automatic model_frame();
        int          n, nb;
        logic        err, ok;
        logic [7:0]  v;
        logic [15:0] tail;
        n  = frm.size();
        nb = n / 8;
        for (int k = 0; k + 2 < nb; k++) begin
            for (int j = 0; j < 8; j++) v[j] = frm[8*k + j];
            exp_b.push_back({(k == 0), v});
        end
        if (n > 0) begin
            err = (n % 8 != 0) || (nb < 3);
            ok  = 1'b0;
            if (!err) begin
                for (int j = 0; j < 16; j++) tail[j] = frm[n - 16 + j];
                ok = (tail == ~crc_over(n - 16));
            end
            exp_e.push_back({ok, err});
        end
    endtask

    task automatic send_line();
        int ones;
        ones = 0;
        foreach (frm[i]) begin
            send_bit(frm[i]);
            ones = frm[i] ? ones + 1 : 0;
            if (ones == 5) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
        frm.delete();
    endtask

    task automatic send_frm();
        model_frame();
        send_line();
    endtask

    task automatic check_rx(input string tag);
        chk({tag, " nbytes"}, 32'(got_b.size()), 32'(exp_b.size()));
        for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
            chk({tag, " byte"}, 32'(got_b[i]), 32'(exp_b[i]));
        chk({tag, " neof"}, 32'(got_e.size()), 32'(exp_e.size()));
        for (int i = 0; i < got_e.size() && i < exp_e.size(); i++)
            chk({tag, " eof ok/err"}, 32'(got_e[i]), 32'(exp_e[i]));
        got_b.delete(); exp_b.delete();
        got_e.delete(); exp_e.delete();
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " strobes"}, 32'({rif.rx_valid, rif.rx_sof, rif.rx_eof, rif.rx_crc_ok, rif.rx_error}), 32'd0);
        chk({tag, " levels"}, 32'({rif.abort, rif.idle}), 32'd0);
        chk({tag, " rx_data"}, 32'(rif.rx_data), 32'h00);
    endtask

    initial begin
        int         len;
        int         idx;
        logic [7:0] v;

        reset = 1'b0;
        repeat (3) send_bit(1'b1);
        check_quiet("reset");
        reset = 1'b1;

        // single byte after flag fill
        repeat (4) send_flag();
        add_byte(8'h53); add_fcs(); send_frm();
        send_flag();
        check_rx("one byte");
        chk("rx_data hold", 32'(rif.rx_data), 32'h53);

        // payload that forces stuffing on the line
        abort_seen = 1'b0;
        add_byte(8'hFF); add_byte(8'h7E); add_fcs(); send_frm();
        send_flag();
        check_rx("stuffed");
        chk("stuffed no abort", 32'(abort_seen), 32'd0);

        // two frames sharing one flag
        add_byte(8'h01); add_byte(8'h02); add_fcs(); send_frm();
        send_flag();
        add_byte(8'h03); add_fcs(); send_frm();
        send_flag();
        check_rx("shared flag");

        // corrupted FCS bit
        add_byte(8'hC3); add_byte(8'h11); add_fcs();
        frm[frm.size() - 5] = ~frm[frm.size() - 5];
        send_frm();
        send_flag();
        check_rx("bad fcs");

        // 13-bit frame
        add_byte(8'h53);
        frm.push_back(1'b1); frm.push_back(1'b0); frm.push_back(1'b1);
        frm.push_back(1'b1); frm.push_back(1'b0);
        send_frm();
        send_flag();
        check_rx("13 bits");

        // abort then idle then flag
        send_raw8(8'h53);
        for (int i = 1; i <= 22; i++) begin
            send_bit(1'b1);
            if (i == 6)  chk("abort before 7th one", 32'(rif.abort), 32'd0);
            if (i == 7)  chk("abort at 7th one", 32'(rif.abort), 32'd1);
            if (i == 14) chk("idle before 15th one", 32'(rif.idle), 32'd0);
            if (i == 15) chk("idle at 15th one", 32'(rif.idle), 32'd1);
        end
        chk("idle held", 32'({rif.abort, rif.idle}), 32'b11);
        send_bit(1'b0);
        chk("idle cleared by 0", 32'({rif.abort, rif.idle}), 32'b10);
        repeat (6) send_bit(1'b1);
        send_bit(1'b0);
        chk("abort cleared by flag", 32'(rif.abort), 32'd0);
        check_rx("abort");

        // reset mid-payload, then a clean frame
        add_byte(8'hA5); add_byte(8'h3C); add_byte(8'h0F);
        repeat (4) frm.pop_back();
        send_line();
        reset = 1'b0;
        send_bit(1'b1);
        reset = 1'b1;
        check_quiet("mid reset");
        send_flag();
        add_byte(8'h5A); add_byte(8'hE7); add_byte(8'h42); add_fcs(); send_frm();
        send_flag();
        check_rx("after reset");

        // random frames, occasional flag fill and corrupted bit
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(0, 2)) send_flag();
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                v = 8'($urandom);
                add_byte(v);
            end
            add_fcs();
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, frm.size() - 1);
                frm[idx] = ~frm[idx];
            end
            send_frm();
            send_flag();
            check_rx("random");
        end
        chk("final levels", 32'({rif.abort, rif.idle}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
